mem_access_unit: RTL and testbench

- Load/store front end placed directly upstream of the word-organised data memory.
- Converts CPU byte-addressed requests (lw/lh/lhu/lb/lbu/sw/sh/sb) into word-index accesses.
- Does sign/zero extension on loads and read-modify-write merging on sub-word stores.
- Flags misaligned and out-of-range accesses; holds the pipeline via req_ready until the response.

---
 rtl/mem_access_unit.sv | 190 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store front end that turns byte-addressed CPU requests into word-index memory accesses.
// Optional MEM_ACCESS_STATS_EN adds completed-load/store/error counters.
module mem_access_unit #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [31:0]       dm_addr,
  output logic [31:0]       dm_wdata,
  output logic              dm_MemWrite,
  output logic              dm_MemRead,
  input  logic [31:0]       dm_rdata
`ifdef MEM_ACCESS_STATS_EN
  ,
  output logic [31:0]       stat_loads,
  output logic [31:0]       stat_stores,
  output logic [31:0]       stat_errs
`endif
);

  typedef enum logic [2:0] {StIdle, StLoad, StStore, StRmwRd, StRmwWr, StResp} state_e;

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       merge_q, merge_d;

  logic        req_err;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [4:0]  shamt;
  logic [31:0] lane_mask;
  logic [31:0] merged;

  assign req_err = (req_size == 2'd3)
                || (req_size == 2'd1 && req_addr[0])
                || (req_size == 2'd2 && req_addr[1:0] != 2'd0)
                || ((req_addr >> (ADDR_W + 2)) != 32'd0);

  always_comb begin
    ld_byte = dm_rdata[7:0];
    unique case (lane_q)
      2'd0: ld_byte = dm_rdata[7:0];
      2'd1: ld_byte = dm_rdata[15:8];
      2'd2: ld_byte = dm_rdata[23:16];
      2'd3: ld_byte = dm_rdata[31:24];
      default: ld_byte = dm_rdata[7:0];
    endcase
    ld_half = lane_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    unique case (size_q)
      2'd0:    ld_ext = {{24{ld_byte[7] & ~uns_q}}, ld_byte};
      2'd1:    ld_ext = {{16{ld_half[15] & ~uns_q}}, ld_half};
      default: ld_ext = dm_rdata;
    endcase
  end

  // Sub-word store merge: replace the addressed lane(s) of the word just read.
  assign shamt     = {lane_q, 3'b000};
  assign lane_mask = ((size_q == 2'd1) ? 32'h0000_FFFF : 32'h0000_00FF) << shamt;
  assign merged    = (dm_rdata & ~lane_mask) | ((wdata_q << shamt) & lane_mask);

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    size_d  = size_q;
    uns_d   = uns_q;
    lane_d  = lane_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    merge_d = merge_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          write_d = req_write;
          size_d  = req_size;
          uns_d   = req_unsigned;
          lane_d  = req_addr[1:0];
          wdata_d = req_wdata;
          err_d   = req_err;
          rdata_d = 32'd0;
          if (req_err) begin
            state_d = StResp;
          end else begin
            addr_d = req_addr[ADDR_W+1:2];
            if (!req_write) begin
              state_d = StLoad;
            end else if (req_size == 2'd2) begin
              merge_d = req_wdata;
              state_d = StStore;
            end else begin
              state_d = StRmwRd;
            end
          end
        end
      end
      StLoad: begin
        rdata_d = ld_ext;
        state_d = StResp;
      end
      StStore: state_d = StResp;
      StRmwRd: begin
        merge_d = merged;
        state_d = StRmwWr;
      end
      StRmwWr: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      write_q <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      lane_q  <= 2'd0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
      addr_q  <= '0;
      merge_q <= 32'd0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      lane_q  <= lane_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      merge_q <= merge_d;
    end
  end

  assign req_ready   = (state_q == StIdle);
  assign rsp_valid   = (state_q == StResp) && !reset;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign dm_addr     = {{(32 - ADDR_W){1'b0}}, addr_q};
  assign dm_wdata    = merge_q;
  assign dm_MemRead  = (state_q == StLoad) || (state_q == StRmwRd);
  // A reset landing on a write cycle must not corrupt memory.
  assign dm_MemWrite = ((state_q == StStore) || (state_q == StRmwWr)) && !reset;

`ifdef MEM_ACCESS_STATS_EN
  logic [31:0] loads_q, stores_q, errs_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      loads_q  <= 32'd0;
      stores_q <= 32'd0;
      errs_q   <= 32'd0;
    end else if (state_q == StResp) begin
      if (err_q) begin
        errs_q <= errs_q + 32'd1;
      end else if (write_q) begin
        stores_q <= stores_q + 32'd1;
      end else begin
        loads_q <= loads_q + 32'd1;
      end
    end
  end

  assign stat_loads  = loads_q;
  assign stat_stores = stores_q;
  assign stat_errs   = errs_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: driver pushes model expectations, monitor checks responses.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata, dm_addr, dm_wdata, dm_rdata;
  logic        dm_MemWrite, dm_MemRead;
`ifdef MEM_ACCESS_STATS_EN
  logic [31:0] stat_loads, stat_stores, stat_errs;
  int          exp_loads = 0, exp_stores = 0, exp_errs = 0;
`endif

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(10)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_MemWrite(dm_MemWrite), .dm_MemRead(dm_MemRead), .dm_rdata(dm_rdata)
`ifdef MEM_ACCESS_STATS_EN
    , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_errs(stat_errs)
`endif
  );

  // Environment memory (what the DUT talks to) and the reference image.
  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];
  assign dm_rdata = mem[dm_addr[9:0]];
  always @(posedge clk) if (dm_MemWrite) mem[dm_addr[9:0]] <= dm_wdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour straight from the access rules.
  function automatic exp_t model(input logic wr, input logic [1:0] sz, input logic uns,
                                 input logic [31:0] a, input logic [31:0] wd);
    exp_t        e;
    logic [31:0] w, v, mask;
    int          idx, k;
    e.rdata = 32'd0; e.err = 1'b0; e.lat = 2; e.nrd = 0; e.nwr = 0;
    if (sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || a >= 32'h1000) begin
      e.err = 1'b1; e.lat = 1;
`ifdef MEM_ACCESS_STATS_EN
      exp_errs++;
`endif
      return e;
    end
    idx = int'(a[11:2]);
    k   = int'(a[1:0]);
    w   = ref_mem[idx];
    if (!wr) begin
      e.nrd = 1;
      if (sz == 2'd2) begin
        e.rdata = w;
      end else if (sz == 2'd1) begin
        v = (w >> (8 * k)) & 32'hFFFF;
        e.rdata = (!uns && v[15]) ? (v | 32'hFFFF_0000) : v;
      end else begin
        v = (w >> (8 * k)) & 32'hFF;
        e.rdata = (!uns && v[7]) ? (v | 32'hFFFF_FF00) : v;
      end
`ifdef MEM_ACCESS_STATS_EN
      exp_loads++;
`endif
    end else begin
      e.nwr = 1;
      if (sz == 2'd2) begin
        ref_mem[idx] = wd;
      end else begin
        mask = ((sz == 2'd1) ? 32'hFFFF : 32'hFF) << (8 * k);
        ref_mem[idx] = (w & ~mask) | ((wd << (8 * k)) & mask);
        e.nrd = 1; e.lat = 3;
      end
`ifdef MEM_ACCESS_STATS_EN
      exp_stores++;
`endif
    end
    return e;
  endfunction

  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input bit keep, input bit expect_rsp);
    int n;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    n = 0;
    @(negedge clk);
    while (!req_ready) begin
      if (n == 50) begin
        checks++; failures++;
        $display("FAIL accept_timeout: req_ready stayed 0 for addr 0x%08h", a);
        req_valid = 1'b0;
        return;
      end
      n++;
      @(negedge clk);
    end
    if (expect_rsp) q.push_back(model(wr, sz, uns, a, wd));
    if (!keep) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
  endtask

  // Monitor: samples on the falling edge, tracks each transaction from accept to response.
  int cyc = 0, acc_cyc = 0, nrd = 0, nwr = 0;
  bit busy = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (reset) begin
      busy = 1'b0; nrd = 0; nwr = 0;
    end else begin
      check("req_ready", {31'd0, req_ready}, {31'd0, !busy});
      if (busy) begin
        nrd += int'(dm_MemRead);
        nwr += int'(dm_MemWrite);
      end
      if (rsp_valid) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_rsp: rsp_valid=1 with no pending request at %0t", $time);
        end else begin
          e = q.pop_front();
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
          check("latency", cyc - acc_cyc, e.lat);
          check("mem_reads", nrd, e.nrd);
          check("mem_writes", nwr, e.nwr);
        end
        busy = 1'b0;
      end
      if (req_valid && req_ready) begin
        busy = 1'b1; acc_cyc = cyc; nrd = 0; nwr = 0;
      end
    end
  end

  initial begin
    logic [31:0] a, w;
    logic [1:0]  sz;
    int          n;
    for (int i = 0; i < 1024; i++) begin
      w = $urandom;
      mem[i] = w;
      ref_mem[i] = w;
    end
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_dm_addr", dm_addr, 32'd0);
    check("rst_dm_wdata", dm_wdata, 32'd0);
    check("rst_dm_rw", {30'd0, dm_MemWrite, dm_MemRead}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    reset = 1'b0;

    // Word store then load back.
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b1);
    check("sw_dm_addr", dm_addr, 32'd4);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b0, 1'b1);
    // Sub-word store merge.
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344, 1'b0, 1'b1);
    issue(1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_00AA, 1'b0, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b0, 1'b1);
    // Load extension.
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h8000_F0FF, 1'b0, 1'b1);
    issue(1'b0, 2'd0, 1'b0, 32'h10, 32'd0, 1'b0, 1'b1);
    issue(1'b0, 2'd0, 1'b1, 32'h11, 32'd0, 1'b0, 1'b1);
    issue(1'b0, 2'd1, 1'b0, 32'h12, 32'd0, 1'b0, 1'b1);
    issue(1'b0, 2'd1, 1'b1, 32'h12, 32'd0, 1'b0, 1'b1);
    // Errors.
    issue(1'b0, 2'd1, 1'b0, 32'h11, 32'd0, 1'b0, 1'b1);
    issue(1'b1, 2'd2, 1'b0, 32'h12, 32'h1234_5678, 1'b0, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 32'h1000, 32'd0, 1'b0, 1'b1);
    issue(1'b0, 2'd3, 1'b0, 32'h10, 32'd0, 1'b0, 1'b1);
    // Reset during RMW_WR drops the store and its response.
    issue(1'b1, 2'd1, 1'b0, 32'h10, 32'h0000_5555, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b0, 1'b1);
    // Two loads with req_valid held high.
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b1, 1'b1);
    issue(1'b0, 2'd0, 1'b0, 32'h12, 32'd0, 1'b0, 1'b1);

    // Randomized traffic over a small window so loads see earlier stores.
    for (int i = 0; i < 300; i++) begin
      a  = $urandom_range(0, 15) * 4 + $urandom_range(0, 3);
      if ($urandom_range(0, 15) == 0) a = a | (32'h1 << $urandom_range(12, 31));
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
            1'($urandom_range(0, 1) == 1 && i != 299), 1'b1);
    end

    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("pending_rsps", q.size(), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 1024; i++) check("mem_image", mem[i], ref_mem[i]);
`ifdef MEM_ACCESS_STATS_EN
    check("stat_loads", stat_loads, exp_loads);
    check("stat_stores", stat_stores, exp_stores);
    check("stat_errs", stat_errs, exp_errs);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
